int_to_fp_iter: RTL and testbench

Iterative integer-to-floating-point encoder: accepts a signed or unsigned integer on a valid/ready input and produces the packed IEEE-style FP word (SIGN_W/EXPO_W/MANT_W format) on a valid/ready output. It normalizes by shifting one bit per cycle, so it uses small area at variable latency. It is the constructive counterpart to the FP classifiers (zero/inf checks) in the min datapath. An all-zero integer yields the canonical +0 encoding: exponent 0, mantissa 0.

---
 rtl/int_to_fp_iter_pkg.sv | 20 ++
 rtl/int_to_fp_iter_if.sv | 28 ++
 rtl/int_to_fp_iter_pack.sv | 17 +
 rtl/int_to_fp_iter.sv | 131 +++++++++++++
 tb/tb_int_to_fp_iter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_to_fp_iter_pkg.sv
// Shared types and derived-constant helpers for the iterative integer-to-FP encoder.
package fp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      DONE
   } state_e;

   function automatic int unsigned fp_w(input int unsigned sign_w,
                                        input int unsigned expo_w,
                                        input int unsigned mant_w);
      return sign_w + expo_w + mant_w;
   endfunction

   function automatic int unsigned bias(input int unsigned expo_w);
      return (32'd1 << (expo_w - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/int_to_fp_iter_if.sv
// Valid/ready request and response bundle of the integer-to-FP encoder.
interface int_to_fp_iter_if
   import fp_pkg::*;
#(
   parameter int unsigned INT_W = 32,
   parameter int unsigned FP_W  = fp_w(1, 8, 23)
);

   logic             in_valid;
   logic             in_ready;
   logic [INT_W-1:0] in_int;
   logic             in_signed;
   logic             out_valid;
   logic             out_ready;
   logic [FP_W-1:0]  out_fp;
   logic             out_inexact;

   modport master (
      output in_valid, in_int, in_signed, out_ready,
      input  in_ready, out_valid, out_fp, out_inexact
   );

   modport slave (
      input  in_valid, in_int, in_signed, out_ready,
      output in_ready, out_valid, out_fp, out_inexact
   );

endinterface

// File: rtl/int_to_fp_iter_pack.sv
// Combinational packer: {sign, exponent, fraction} into one FP word.
module fp_pack
   import fp_pkg::*;
#(
   parameter int unsigned SIGN_W = 1,
   parameter int unsigned EXPO_W = 8,
   parameter int unsigned MANT_W = 23
) (
   input  logic [SIGN_W-1:0]                     sign,
   input  logic [EXPO_W-1:0]                     expo,
   input  logic [MANT_W-1:0]                     frac,
   output logic [fp_w(SIGN_W, EXPO_W, MANT_W)-1:0] fp
);

   assign fp = {sign, expo, frac};

endmodule

// File: rtl/int_to_fp_iter.sv
// Iterative integer-to-FP encoder: normalizes one bit per cycle, truncating the fraction.
module int_to_fp_iter
   import fp_pkg::*;
#(
   parameter int unsigned SIGN_W = 1,
   parameter int unsigned EXPO_W = 8,
   parameter int unsigned MANT_W = 23,
   parameter int unsigned INT_W  = 32
) (
   input logic            clk,
   input logic            rst,
   int_to_fp_iter_if.slave io
);

   localparam int unsigned FP_W  = fp_w(SIGN_W, EXPO_W, MANT_W);
   localparam int unsigned BIAS  = bias(EXPO_W);
   localparam int unsigned EXT_W = INT_W - 1 + MANT_W;

   localparam logic [EXPO_W:0]  EXPO_INIT = (EXPO_W + 1)'(BIAS + INT_W - 1);
   localparam logic [EXPO_W:0]  EXPO_ONE  = (EXPO_W + 1)'(1);
   localparam logic [INT_W-1:0] INT_ONE   = INT_W'(1);

   if (SIGN_W != 1) begin : g_sign_chk
      $error("int_to_fp_iter: SIGN_W must be 1");
   end
   if (INT_W < 2 || INT_W - 1 > BIAS) begin : g_range_chk
      $error("int_to_fp_iter: INT_W-1 must not exceed BIAS");
   end

   state_e              state_q, state_d;
   logic [INT_W-1:0]    mag_q, mag_d;
   logic [EXPO_W:0]     expo_q, expo_d;
   logic [SIGN_W-1:0]   sign_q, sign_d;
   logic [FP_W-1:0]     out_fp_q, out_fp_d;
   logic                out_inexact_q, out_inexact_d;

   logic                in_neg;
   logic [INT_W-1:0]    in_mag;
   logic [EXT_W-1:0]    ext;
   logic [MANT_W-1:0]   frac;
   logic                dropped;
   logic [FP_W-1:0]     packed_fp;

   // Bits below the leading one, zero-padded on the right so narrow integers still fill the fraction.
   assign ext     = {mag_q[INT_W-2:0], {MANT_W{1'b0}}};
   assign frac    = ext[EXT_W-1 -: MANT_W];
   assign dropped = |ext[INT_W-2:0];

   assign in_neg = io.in_signed & io.in_int[INT_W-1];
   assign in_mag = in_neg ? (~io.in_int + INT_ONE) : io.in_int;

   fp_pack #(
      .SIGN_W (SIGN_W),
      .EXPO_W (EXPO_W),
      .MANT_W (MANT_W)
   ) u_pack (
      .sign (sign_q),
      .expo (expo_q[EXPO_W-1:0]),
      .frac (frac),
      .fp   (packed_fp)
   );

   always_comb begin
      state_d       = state_q;
      mag_d         = mag_q;
      expo_d        = expo_q;
      sign_d        = sign_q;
      out_fp_d      = out_fp_q;
      out_inexact_d = out_inexact_q;

      unique case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               expo_d = EXPO_INIT;
               if (in_mag == '0) begin
                  sign_d        = '0;
                  mag_d         = '0;
                  out_fp_d      = '0;
                  out_inexact_d = 1'b0;
                  state_d       = DONE;
               end else begin
                  sign_d  = SIGN_W'(in_neg);
                  mag_d   = in_mag;
                  state_d = NORM;
               end
            end
         end
         NORM: begin
            // The zero-exponent guard cannot trigger for legal widths; it only bounds the loop.
            if (mag_q[INT_W-1] || expo_q == '0) begin
               out_fp_d      = packed_fp;
               out_inexact_d = dropped;
               state_d       = DONE;
            end else begin
               mag_d  = mag_q << 1;
               expo_d = expo_q - EXPO_ONE;
            end
         end
         DONE: begin
            if (io.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         mag_q         <= '0;
         expo_q        <= '0;
         sign_q        <= '0;
         out_fp_q      <= '0;
         out_inexact_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mag_q         <= mag_d;
         expo_q        <= expo_d;
         sign_q        <= sign_d;
         out_fp_q      <= out_fp_d;
         out_inexact_q <= out_inexact_d;
      end
   end

   assign io.in_ready    = (state_q == IDLE) & ~rst;
   assign io.out_valid   = (state_q == DONE);
   assign io.out_fp      = out_fp_q;
   assign io.out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_fp_iter.sv
// Scoreboard bench for int_to_fp_iter with an arithmetic reference model.
module tb_int_to_fp_iter;

   localparam int INT_W  = 32;
   localparam int FP_W   = 32;
   localparam int MANT_W = 23;
   localparam int BIAS   = 127;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int_to_fp_iter_if #(.INT_W(INT_W), .FP_W(FP_W)) bus ();

   int_to_fp_iter #(
      .SIGN_W (1),
      .EXPO_W (8),
      .MANT_W (MANT_W),
      .INT_W  (INT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   typedef struct {
      logic [31:0] fp;
      logic        inex;
      int          lat;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic force_rdy = 1'b0;
   logic force_val = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      bus.out_ready = force_rdy ? force_val : ($urandom_range(0, 1) == 1);
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, want);
      end
   endtask

   // Reference: value = 2^p * 1.f, truncated toward zero.
   function automatic void model(input logic [31:0] v, input logic s,
                                 output logic [31:0] fp, output logic inex, output int lat);
      longint unsigned m, mant;
      int p;
      logic neg;
      neg = s & v[31];
      m = neg ? ((64'd1 << 32) - {32'd0, v}) : {32'd0, v};
      if (m == 0) begin
         fp = 32'd0; inex = 1'b0; lat = 1;
         return;
      end
      p = 0;
      while ((m >> (p + 1)) != 0) p++;
      if (p >= MANT_W) begin
         mant = m >> (p - MANT_W);
         inex = (m % (64'd1 << (p - MANT_W))) != 0;
      end else begin
         mant = m << (MANT_W - p);
         inex = 1'b0;
      end
      mant = mant - (64'd1 << MANT_W);
      fp   = {neg, 8'(BIAS + p), mant[22:0]};
      lat  = 2 + (INT_W - 1 - p);
   endfunction

   logic prev_v = 1'b0;
   exp_t cur;
   int   lat_m;

   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
         if (bus.out_valid) begin
            check("in_ready_low_in_done", 64'(bus.in_ready), 64'd0);
            if (!prev_v) begin
               if (exp_q.size() == 0 || acc_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got %h expected none", bus.out_fp);
               end else begin
                  cur   = exp_q.pop_front();
                  lat_m = cyc - acc_q.pop_front();
                  check({cur.name, "_fp"}, 64'(bus.out_fp), 64'(cur.fp));
                  check({cur.name, "_inexact"}, 64'(bus.out_inexact), 64'(cur.inex));
                  check({cur.name, "_latency"}, 64'(lat_m), 64'(cur.lat));
               end
            end else begin
               check("hold_fp", 64'(bus.out_fp), 64'(cur.fp));
               check("hold_inexact", 64'(bus.out_inexact), 64'(cur.inex));
            end
         end
         prev_v = bus.out_valid;
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [31:0] v, input logic s, input string nm);
      exp_t e;
      bit   ok;
      model(v, s, e.fp, e.inex, e.lat);
      e.name = nm;
      exp_q.push_back(e);
      bus.in_int    = v;
      bus.in_signed = s;
      bus.in_valid  = 1'b1;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.in_int    = $urandom;
      bus.in_signed = $urandom_range(0, 1);
      if (!ok) begin
         void'(exp_q.pop_back());
         check({nm, "_accept_timeout"}, 64'd0, 64'd1);
      end
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   seen;
      logic [31:0] held;
      logic [31:0] v;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_int    = '0;
      bus.in_signed = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_fp", 64'(bus.out_fp), 64'd0);
      check("rst_out_inexact", 64'(bus.out_inexact), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;

      send(32'h0000_0000, 1'b0, "u_zero");
      send(32'h8000_0000, 1'b1, "s_min");
      send(32'h0000_0001, 1'b0, "u_one");
      send(32'hFFFF_FFFF, 1'b1, "s_minus_one");
      send(32'hFFFF_FFFF, 1'b0, "u_max");
      send(32'h00FF_FFFF, 1'b0, "u_24bit");
      send(32'h0000_0000, 1'b1, "s_zero");
      send(32'h8000_0000, 1'b0, "u_msb");
      drain();

      // Backpressure: five stalled cycles in DONE, handshake on the sixth.
      force_val = 1'b0;
      force_rdy = 1'b1;
      send(32'h0001_2345, 1'b1, "bp");
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1;
            break;
         end
      end
      check("bp_valid_seen", 64'(seen), 64'd1);
      held = bus.out_fp;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_stall_valid", 64'(bus.out_valid), 64'd1);
         check("bp_stall_fp", 64'(bus.out_fp), 64'(held));
         check("bp_stall_in_ready", 64'(bus.in_ready), 64'd0);
      end
      @(posedge clk);
      #1 force_val = 1'b1;
      @(negedge clk);
      check("bp_handshake_valid", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
      check("bp_after_in_ready", 64'(bus.in_ready), 64'd1);
      check("bp_after_valid", 64'(bus.out_valid), 64'd0);
      force_rdy = 1'b0;
      drain();

      // Reset mid-NORM drops the operation.
      send(32'h0000_0001, 1'b0, "rst_mid");
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready_comb", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
      check("rst_mid_fp", 64'(bus.out_fp), 64'd0);
      check("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
      exp_q.delete();
      acc_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_release_in_ready", 64'(bus.in_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1;
      end
      check("rst_no_stale_result", 64'(seen), 64'd0);
      @(posedge clk);
      #1;

      for (int n = 0; n < 80; n++) begin
         v = $urandom;
         v = v >> $urandom_range(0, 31);
         if ($urandom_range(0, 15) == 0) v = '0;
         send(v, $urandom_range(0, 1) == 1, "rand");
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
